frac_search_ctrl: RTL

Sequencer and two-way arbiter for the 8x8 fractional-pel search datapath. Accepts block-search requests from two requesters, fetches the 8 filtered rows and 8 reference rows of the selected block from the row memories, and streams them into the search datapath with a row-valid strobe. It then captures the resulting motion vector and returns it with the requester id over a valid/ready result port.

---
 rtl/frac_pkg.sv | 9 +
 rtl/rr_arb2.sv | 22 ++
 rtl/frac_search_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/frac_pkg.sv
// Shared types and constants for the fractional-pel search sequencer.
package frac_pkg;
    typedef enum logic [1:0] {IDLE, FETCH, WAIT, HOLD} state_t;

    localparam int ROWS  = 8;
    localparam int PIX_W = 64;
    localparam int MV_W  = 3;
    localparam int ROW_W = 3;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the last-grant pointer starts at 1 so requester 0 wins first.
module rr_arb2 (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    input  logic i_valid0,
    input  logic i_valid1,
    output logic o_grant0,
    output logic o_grant1
);
    logic r_last;

    assign o_grant0 = i_en & i_valid0 & (~i_valid1 | r_last);
    assign o_grant1 = i_en & i_valid1 & (~i_valid0 | ~r_last);

    always_ff @(posedge clk) begin
        if (reset)
            r_last <= 1'b1;
        else if (o_grant0 | o_grant1)
            r_last <= o_grant1;
    end
endmodule

// File: rtl/frac_search_ctrl.sv
// Block-search sequencer: arbitrates two requesters, streams 8 row pairs, captures the MV.
// Optional busy-cycle counter enabled by FRAC_SEARCH_CTRL_PERF_EN.
module frac_search_ctrl
    import frac_pkg::*;
#(
    parameter int BLK_W   = 3,
    parameter int RES_LAT = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req0_valid,
    input  logic [BLK_W-1:0]   req0_blk,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [BLK_W-1:0]   req1_blk,
    output logic               req1_ready,
    output logic               mem_rd,
    output logic [BLK_W+2:0]   mem_addr,
    input  logic [PIX_W-1:0]   mem_filter_row,
    input  logic [PIX_W-1:0]   mem_ref_row,
    output logic [PIX_W-1:0]   fs_filter_pix,
    output logic [PIX_W-1:0]   fs_ref_pix,
    output logic               fs_input_ready,
    input  logic [MV_W-1:0]    fs_mvx,
    input  logic [MV_W-1:0]    fs_mvy,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               res_id,
    output logic [MV_W-1:0]    res_mvx,
    output logic [MV_W-1:0]    res_mvy,
`ifdef FRAC_SEARCH_CTRL_PERF_EN
    input  logic               perf_clear,
    output logic [15:0]        perf_busy_cycles,
`endif
    output logic               busy
);
    localparam logic [2:0]       LAT      = 3'(RES_LAT);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    state_t             r_state, w_next;
    logic [BLK_W-1:0]   r_blk;
    logic               r_id;
    logic [ROW_W-1:0]   r_row;
    logic [2:0]         r_lat;
    logic               r_fs_vld;
    logic [MV_W-1:0]    r_mvx, r_mvy;
    logic               w_grant0, w_grant1, w_mem_rd;

    rr_arb2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .i_en     (r_state == IDLE),
        .i_valid0 (req0_valid),
        .i_valid1 (req1_valid),
        .o_grant0 (w_grant0),
        .o_grant1 (w_grant1)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_grant0 | w_grant1) w_next = FETCH;
            FETCH:   if (r_row == ROW_LAST)   w_next = WAIT;
            WAIT:    if (r_lat == LAT)        w_next = HOLD;
            HOLD:    if (res_ready)           w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_mem_rd = (r_state == FETCH);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_blk    <= '0;
            r_id     <= 1'b0;
            r_row    <= '0;
            r_lat    <= '0;
            r_fs_vld <= 1'b0;
            r_mvx    <= '0;
            r_mvy    <= '0;
        end else begin
            r_state  <= w_next;
            r_fs_vld <= w_mem_rd;
            case (r_state)
                IDLE: if (w_grant0 | w_grant1) begin
                    r_blk <= w_grant1 ? req1_blk : req0_blk;
                    r_id  <= w_grant1;
                    r_row <= '0;
                end
                FETCH: begin
                    r_row <= r_row + 3'd1;
                    r_lat <= '0;
                end
                // The datapath result is stable RES_LAT cycles after the last row strobe.
                WAIT: begin
                    r_lat <= r_lat + 3'd1;
                    if (r_lat == LAT) begin
                        r_mvx <= fs_mvx;
                        r_mvy <= fs_mvy;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req0_ready     = w_grant0;
    assign req1_ready     = w_grant1;
    assign mem_rd         = w_mem_rd;
    assign mem_addr       = {r_blk, r_row};
    assign fs_input_ready = r_fs_vld;
    assign fs_filter_pix  = r_fs_vld ? mem_filter_row : '0;
    assign fs_ref_pix     = r_fs_vld ? mem_ref_row : '0;
    assign res_valid      = (r_state == HOLD);
    assign res_id         = r_id;
    assign res_mvx        = r_mvx;
    assign res_mvy        = r_mvy;
    assign busy           = (r_state != IDLE);

`ifdef FRAC_SEARCH_CTRL_PERF_EN
    logic [15:0] r_perf;

    always_ff @(posedge clk) begin
        if (reset || perf_clear)
            r_perf <= '0;
        else if (busy && r_perf != 16'hFFFF)
            r_perf <= r_perf + 16'd1;
    end

    assign perf_busy_cycles = r_perf;
`endif
endmodule
